// File: rtl/difficulty_sequencer.sv
// Round pacing for the playfield: counts survived frames, raises the level on a fixed
// schedule, drives wall/rotation speeds, reverses spin pseudo-randomly and tracks the best time.
module difficulty_sequencer #(
    parameter int LEVEL_FRAMES    = 600,
    parameter int MAX_LEVEL       = 5,
    parameter int SPEED_W         = 8,
    parameter int BASE_WALL_SPEED = 2,
    parameter int WALL_STEP       = 1,
    parameter int BASE_ROT_SPEED  = 1,
    parameter int ROT_STEP        = 1,
    parameter int FLIP_MIN        = 60
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_update,
    input  logic               i_reset_game,
    input  logic               i_game_over,
    output logic [SPEED_W-1:0] o_wall_speed,
    output logic [SPEED_W-1:0] o_rot_speed,
    output logic               o_rot_dir,
    output logic               o_spin_flip,
    output logic [2:0]         o_level,
    output logic               o_level_up,
    output logic [15:0]        o_frames,
    output logic [15:0]        o_best_frames
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam logic [SPEED_W-1:0] SPEED_MAX = '1;
    localparam logic [SPEED_W-1:0] WALL_BASE = SPEED_W'(BASE_WALL_SPEED);
    localparam logic [SPEED_W-1:0] ROT_BASE  = SPEED_W'(BASE_ROT_SPEED);
    localparam logic [SPEED_W-1:0] WALL_INC  = SPEED_W'(WALL_STEP);
    localparam logic [SPEED_W-1:0] ROT_INC   = SPEED_W'(ROT_STEP);
    localparam logic [15:0]        LVL_LAST  = 16'(LEVEL_FRAMES - 1);
    localparam logic [2:0]         LVL_MAX   = 3'(MAX_LEVEL);
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;
    localparam logic [15:0]        LFSR_MASK = 16'hB400;

    function automatic logic [SPEED_W-1:0] sat_add(input logic [SPEED_W-1:0] a,
                                                   input logic [SPEED_W-1:0] b);
        logic [SPEED_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SPEED_W] ? SPEED_MAX : sum[SPEED_W-1:0];
    endfunction

    state_t             r_state, w_state_next;
    logic [15:0]        r_lfsr, w_lfsr_next;
    logic [15:0]        r_frames, w_frames_next;
    logic [15:0]        r_best, w_best_next;
    logic [15:0]        r_lvl_cnt, w_lvl_cnt_next;
    logic [15:0]        r_flip_cnt, w_flip_cnt_next;
    logic [15:0]        w_flip_reload;
    logic [2:0]         r_level, w_level_next;
    logic [SPEED_W-1:0] r_wall, w_wall_next;
    logic [SPEED_W-1:0] r_rot, w_rot_next;
    logic               r_rot_dir, w_rot_dir_next;
    logic               r_spin_flip, w_spin_flip_next;
    logic               r_level_up, w_level_up_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_frames    <= '0;
            r_best      <= '0;
            r_lvl_cnt   <= '0;
            r_flip_cnt  <= '0;
            r_level     <= '0;
            r_wall      <= WALL_BASE;
            r_rot       <= ROT_BASE;
            r_rot_dir   <= 1'b0;
            r_spin_flip <= 1'b0;
            r_level_up  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_frames    <= w_frames_next;
            r_best      <= w_best_next;
            r_lvl_cnt   <= w_lvl_cnt_next;
            r_flip_cnt  <= w_flip_cnt_next;
            r_level     <= w_level_next;
            r_wall      <= w_wall_next;
            r_rot       <= w_rot_next;
            r_rot_dir   <= w_rot_dir_next;
            r_spin_flip <= w_spin_flip_next;
            r_level_up  <= w_level_up_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_frames_next    = r_frames;
        w_best_next      = r_best;
        w_lvl_cnt_next   = r_lvl_cnt;
        w_flip_cnt_next  = r_flip_cnt;
        w_level_next     = r_level;
        w_wall_next      = r_wall;
        w_rot_next       = r_rot;
        w_rot_dir_next   = r_rot_dir;
        w_spin_flip_next = 1'b0;
        w_level_up_next  = 1'b0;
        // The LFSR free-runs in every state so the player's timing seeds the spin schedule.
        w_lfsr_next      = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
        w_flip_reload    = 16'(FLIP_MIN) + {10'd0, r_lfsr[5:0]};

        if (i_reset_game) begin
            w_state_next    = ST_RUN;
            w_frames_next   = '0;
            w_level_next    = '0;
            w_lvl_cnt_next  = '0;
            w_wall_next     = WALL_BASE;
            w_rot_next      = ROT_BASE;
            w_rot_dir_next  = 1'b0;
            w_flip_cnt_next = w_flip_reload;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_game_over) begin
                        w_state_next = ST_FROZEN;
                        w_best_next  = (r_frames > r_best) ? r_frames : r_best;
                    end else if (i_update) begin
                        if (r_frames != 16'hFFFF) w_frames_next = r_frames + 16'd1;
                        // Once the top level is reached the level counter parks.
                        if (r_level < LVL_MAX) begin
                            if (r_lvl_cnt == LVL_LAST) begin
                                w_lvl_cnt_next  = '0;
                                w_level_next    = r_level + 3'd1;
                                w_level_up_next = 1'b1;
                                w_wall_next     = sat_add(r_wall, WALL_INC);
                                w_rot_next      = sat_add(r_rot, ROT_INC);
                            end else begin
                                w_lvl_cnt_next = r_lvl_cnt + 16'd1;
                            end
                        end
                        if (r_flip_cnt == 16'd0) begin
                            w_rot_dir_next   = ~r_rot_dir;
                            w_spin_flip_next = 1'b1;
                            w_flip_cnt_next  = w_flip_reload;
                        end else begin
                            w_flip_cnt_next = r_flip_cnt - 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_wall_speed  = r_wall;
    assign o_rot_speed   = r_rot;
    assign o_rot_dir     = r_rot_dir;
    assign o_spin_flip   = r_spin_flip;
    assign o_level       = r_level;
    assign o_level_up    = r_level_up;
    assign o_frames      = r_frames;
    assign o_best_frames = r_best;

endmodule

// File: tb/tb_difficulty_sequencer.sv
// Directed bench for difficulty_sequencer: a round-level model (update counts, flip schedule)
// is compared against the outputs every cycle, plus literal expectations for key moments.
module tb_difficulty_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        update, reset_game, game_over;
    logic [7:0]  wall_speed, rot_speed;
    logic        rot_dir, spin_flip, level_up;
    logic [2:0]  level;
    logic [15:0] frames, best_frames;

    int checks = 0;
    int errors = 0;
    int lvlup_cnt = 0;

    difficulty_sequencer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_update     (update),
        .i_reset_game (reset_game),
        .i_game_over  (game_over),
        .o_wall_speed (wall_speed),
        .o_rot_speed  (rot_speed),
        .o_rot_dir    (rot_dir),
        .o_spin_flip  (spin_flip),
        .o_level      (level),
        .o_level_up   (level_up),
        .o_frames     (frames),
        .o_best_frames(best_frames)
    );

    always #5 clk = ~clk;

    // Model: a round is just a count of accepted updates; everything else derives from it.
    int m_phase;      // 0 idle, 1 running, 2 frozen
    int m_updates;
    int m_best;
    int m_next_flip;  // update number (within the round) on which the next reversal lands
    int m_lfsr;
    bit m_rot_dir, m_flip, m_lvlup;

    function automatic int lvl_of(input int n);
        return (n / 600 > 5) ? 5 : n / 600;
    endfunction

    function automatic int frames_of(input int n);
        return (n > 65535) ? 65535 : n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_updates = 0; m_best = 0; m_next_flip = 0;
            m_lfsr = 'hACE1; m_rot_dir = 0; m_flip = 0; m_lvlup = 0;
        end else begin
            m_flip = 0;
            m_lvlup = 0;
            if (reset_game) begin
                m_phase = 1;
                m_updates = 0;
                m_rot_dir = 0;
                m_next_flip = 60 + (m_lfsr & 63) + 1;
            end else if (m_phase == 1) begin
                if (game_over) begin
                    m_phase = 2;
                    if (frames_of(m_updates) > m_best) m_best = frames_of(m_updates);
                end else if (update) begin
                    m_updates++;
                    if (lvl_of(m_updates) != lvl_of(m_updates - 1)) m_lvlup = 1;
                    if (m_updates == m_next_flip) begin
                        m_rot_dir = ~m_rot_dir;
                        m_flip = 1;
                        m_next_flip = m_updates + 60 + (m_lfsr & 63) + 1;
                    end
                end
            end
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("frames",      32'(frames),      32'(frames_of(m_updates)));
            chk("level",       32'(level),       32'(lvl_of(m_updates)));
            chk("wall_speed",  32'(wall_speed),  32'(2 + lvl_of(m_updates)));
            chk("rot_speed",   32'(rot_speed),   32'(1 + lvl_of(m_updates)));
            chk("level_up",    32'(level_up),    32'(m_lvlup));
            chk("rot_dir",     32'(rot_dir),     32'(m_rot_dir));
            chk("spin_flip",   32'(spin_flip),   32'(m_flip));
            chk("best_frames", 32'(best_frames), 32'(m_best));
        end
    end

    always @(posedge level_up) if (rst_n) lvlup_cnt++;

    task automatic step(input bit u, input bit r, input bit g);
        @(negedge clk);
        update = u;
        reset_game = r;
        game_over = g;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_frames"}, 32'(frames), 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_wall"}, 32'(wall_speed), 2);
        chk({tag, "_rot"}, 32'(rot_speed), 1);
        chk({tag, "_dir"}, 32'(rot_dir), 0);
        chk({tag, "_best"}, 32'(best_frames), 0);
        chk({tag, "_pulses"}, 32'({level_up, spin_flip}), 0);
    endtask

    initial begin
        int  k;
        bit  found;
        rst_n = 1'b0; update = 1'b0; reset_game = 1'b0; game_over = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_values("por");
        @(negedge clk); rst_n = 1'b1;

        // Async reset in the middle of a round.
        step(0, 1, 0);
        repeat (37) step(1, 0, 0);
        step(0, 0, 0);
        chk("t1_frames37", 32'(frames), 37);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk_reset_values("t1_async");
        @(negedge clk); rst_n = 1'b1;

        // Best time across two rounds; updates while frozen are ignored.
        step(0, 1, 0);
        repeat (250) step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t5_best250", 32'(best_frames), 250);
        chk("t5_frames250", 32'(frames), 250);
        step(0, 1, 0);
        repeat (100) step(1, 0, 0);
        step(0, 0, 1);
        repeat (6) step(1, 0, 0);
        step(0, 0, 0);
        chk("t5_best_kept", 32'(best_frames), 250);
        chk("t5_frozen_frames", 32'(frames), 100);

        // reset_game beats update and game_over in the same cycle.
        step(0, 1, 0);
        repeat (40) step(1, 0, 0);
        step(1, 1, 1);
        step(0, 0, 0);
        chk("t6_frames0", 32'(frames), 0);
        chk("t6_level0", 32'(level), 0);
        chk("t6_best", 32'(best_frames), 250);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("t6_still_running", 32'(frames), 1);

        // Level schedule and saturation.
        step(0, 1, 0);
        lvlup_cnt = 0;
        repeat (600) step(1, 0, 0);
        step(0, 0, 0);
        chk("t2_level_up_pulse", 32'(level_up), 1);
        chk("t2_level1", 32'(level), 1);
        chk("t2_wall3", 32'(wall_speed), 3);
        chk("t2_rot2", 32'(rot_speed), 2);
        chk("t2_frames600", 32'(frames), 600);
        step(0, 0, 0);
        chk("t2_level_up_one_clk", 32'(level_up), 0);
        repeat (3000) step(1, 0, 0);
        step(0, 0, 0);
        chk("t3_level5", 32'(level), 5);
        chk("t3_wall7", 32'(wall_speed), 7);
        chk("t3_rot6", 32'(rot_speed), 6);
        chk("t3_frames3600", 32'(frames), 3600);
        repeat (600) step(1, 0, 0);
        step(0, 0, 0);
        chk("t3_level_stays5", 32'(level), 5);
        chk("t3_level_up_count", 32'(lvlup_cnt), 5);

        // Start a round when lfsr[5:0] is zero, so the first reversal is on update 61.
        step(0, 0, 1);
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((m_lfsr & 63) == 0) begin
                found = 1;
                break;
            end
        end
        chk("t4_lfsr_window", 32'(found), 1);
        if (found) begin
            update = 1'b0; reset_game = 1'b1; game_over = 1'b0;
            repeat (60) step(1, 0, 0);
            step(0, 0, 0);
            chk("t4_no_flip_at60", 32'({rot_dir, spin_flip}), 0);
            step(1, 0, 0);
            step(0, 0, 0);
            chk("t4_flip_at61", 32'(spin_flip), 1);
            chk("t4_dir_ccw", 32'(rot_dir), 1);
            k = -1;
            for (int i = 0; i < 200; i++) begin
                step(1, 0, 0);
                step(0, 0, 0);
                if (spin_flip === 1'b1) begin
                    k = i;
                    break;
                end
            end
            chk("t4_second_flip_seen", 32'(k >= 0), 1);
            chk("t4_flip_interval_range", 32'(k >= 60 && k <= 123), 1);
        end

        repeat (3) step(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
